// File: rtl/pc_sequencer.sv
// Program counter and run control: req/done handshake, flag-conditional and
// relative jumps, a bounded call/return stack, halt detection and a RUN-cycle counter.
module pc_sequencer #(
   parameter int D         = 12,
   parameter int OW        = 8,
   parameter int SD        = 4,
   parameter int HALT_ADDR = 128,
   parameter int CW        = 16
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          req,
   input  logic          flag_wr,
   input  logic          zero_in,
   input  logic          carry_in,
   input  logic          neg_in,
   input  logic          br_en,
   input  logic [1:0]    br_cond,
   input  logic          abs_en,
   input  logic          rel_en,
   input  logic          call_en,
   input  logic          ret_en,
   input  logic [D-1:0]  target,
   input  logic [OW-1:0] offset,
   output logic [D-1:0]  prog_ctr,
   output logic          running,
   output logic          done,
   output logic          stk_err,
   output logic [CW-1:0] cycles
);

   localparam int SW = $clog2(SD + 1);
   localparam int AW = (SD > 1) ? $clog2(SD) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   // One resolved action per RUN cycle, already in priority order.
   typedef enum logic [2:0] {
      ACT_INC, ACT_HALT, ACT_ERR, ACT_RET, ACT_CALL, ACT_ABS, ACT_REL
   } action_t;

   state_t        state, state_nxt;
   action_t       act;
   logic [SW-1:0] sp;
   logic [D-1:0]  stack [SD];
   logic [AW-1:0] wr_idx, rd_idx;
   logic          flag_z, flag_c, flag_n;
   logic          cond, ok, at_halt;
   logic [D-1:0]  off_ext;

   assign at_halt = (32'(prog_ctr) == 32'(HALT_ADDR));
   assign off_ext = D'($signed(offset));
   assign wr_idx  = AW'(sp);
   assign rd_idx  = AW'(sp - SW'(1));

   always_comb begin
      case (br_cond)
         2'b00:   cond = flag_z;
         2'b01:   cond = !flag_z;
         2'b10:   cond = flag_c;
         default: cond = flag_n;
      endcase
      ok = !br_en || cond;
   end

   always_comb begin
      act = ACT_INC;
      if (at_halt)                  act = ACT_HALT;
      else if (call_en && ret_en)   act = ACT_ERR;
      else if (ret_en)              act = (sp == '0)     ? ACT_ERR : ACT_RET;
      else if (call_en)             act = (sp == SW'(SD)) ? ACT_ERR : ACT_CALL;
      else if (ok && abs_en)        act = ACT_ABS;
      else if (ok && rel_en)        act = ACT_REL;
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (req) state_nxt = RUN;
         RUN:     if (act == ACT_HALT || act == ACT_ERR) state_nxt = DONE;
         DONE:    if (req) state_nxt = RUN;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      running = (state == RUN);
      done    = (state == DONE);
   end

   // Flags are captured in every state; branches only ever see the registered copy.
   always_ff @(posedge clk) begin
      if (reset) begin
         flag_z <= 1'b0;
         flag_c <= 1'b0;
         flag_n <= 1'b0;
      end else if (flag_wr) begin
         flag_z <= zero_in;
         flag_c <= carry_in;
         flag_n <= neg_in;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         prog_ctr <= '0;
         sp       <= '0;
         stk_err  <= 1'b0;
         cycles   <= '0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (req) begin
                  prog_ctr <= '0;
                  sp       <= '0;
                  stk_err  <= 1'b0;
                  cycles   <= '0;
               end
            end
            RUN: begin
               if (cycles != '1) cycles <= cycles + CW'(1);
               case (act)
                  ACT_ERR:  stk_err <= 1'b1;
                  ACT_RET: begin
                     prog_ctr <= stack[rd_idx];
                     sp       <= sp - SW'(1);
                  end
                  ACT_CALL: begin
                     prog_ctr <= target;
                     sp       <= sp + SW'(1);
                  end
                  ACT_ABS:  prog_ctr <= target;
                  ACT_REL:  prog_ctr <= prog_ctr + off_ext;
                  ACT_INC:  prog_ctr <= prog_ctr + D'(1);
                  default:  ;
               endcase
            end
            default: ;
         endcase
      end
   end

   // NOTE: the return stack is plain storage with no reset; sp alone defines which entries are valid.
   always_ff @(posedge clk) begin
      if (state == RUN && act == ACT_CALL) stack[wr_idx] <= prog_ctr + D'(1);
   end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios followed by random
// control traffic, all compared every cycle against a queue-based behavioural model.
module tb_pc_sequencer;

   localparam int D = 12, OW = 8, SD = 4, HALT = 128, CW = 16;
   localparam int PC_MOD  = 1 << D;
   localparam int CYC_MAX = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          reset, req, flag_wr, zero_in, carry_in, neg_in;
   logic          br_en, abs_en, rel_en, call_en, ret_en;
   logic [1:0]    br_cond;
   logic [D-1:0]  target;
   logic [OW-1:0] offset;
   logic [D-1:0]  prog_ctr;
   logic          running, done, stk_err;
   logic [CW-1:0] cycles;

   pc_sequencer #(.D(D), .OW(OW), .SD(SD), .HALT_ADDR(HALT), .CW(CW)) dut (
      .clk(clk), .reset(reset), .req(req), .flag_wr(flag_wr),
      .zero_in(zero_in), .carry_in(carry_in), .neg_in(neg_in),
      .br_en(br_en), .br_cond(br_cond), .abs_en(abs_en), .rel_en(rel_en),
      .call_en(call_en), .ret_en(ret_en), .target(target), .offset(offset),
      .prog_ctr(prog_ctr), .running(running), .done(done),
      .stk_err(stk_err), .cycles(cycles)
   );

   always #5 clk = ~clk;

   typedef enum {M_IDLE, M_RUN, M_DONE} mode_t;
   mode_t m_st;
   int    m_pc, m_cyc;
   bit    m_err, m_z, m_c, m_n;
   int    m_stk[$];

   int    total = 0;
   int    bad   = 0;
   string step_name = "init";

   task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s/%s observed=%0d expected=%0d", step_name, tag, obs, exp);
      end
   endtask

   // Reference behaviour for one clock edge, using the inputs currently driven.
   task automatic model_step();
      bit c, ok;
      int off;
      if (reset) begin
         m_st = M_IDLE; m_pc = 0; m_cyc = 0; m_err = 0; m_stk.delete();
         m_z = 0; m_c = 0; m_n = 0;
      end else begin
         case (m_st)
            M_IDLE, M_DONE: if (req) begin
               m_st = M_RUN; m_pc = 0; m_cyc = 0; m_err = 0; m_stk.delete();
            end
            default: begin
               if (m_cyc < CYC_MAX) m_cyc++;
               c   = (br_cond == 0) ? m_z : (br_cond == 1) ? !m_z : (br_cond == 2) ? m_c : m_n;
               ok  = !br_en || c;
               off = $signed(offset);
               if (m_pc == HALT) m_st = M_DONE;
               else if (call_en && ret_en) begin m_err = 1; m_st = M_DONE; end
               else if (ret_en) begin
                  if (m_stk.size() == 0) begin m_err = 1; m_st = M_DONE; end
                  else m_pc = m_stk.pop_back();
               end else if (call_en) begin
                  if (m_stk.size() == SD) begin m_err = 1; m_st = M_DONE; end
                  else begin m_stk.push_back((m_pc + 1) % PC_MOD); m_pc = target; end
               end else if (ok && abs_en) m_pc = target;
               else if (ok && rel_en) m_pc = ((m_pc + off) % PC_MOD + PC_MOD) % PC_MOD;
               else m_pc = (m_pc + 1) % PC_MOD;
            end
         endcase
         if (flag_wr) begin m_z = zero_in; m_c = carry_in; m_n = neg_in; end
      end
   endtask

   task automatic clear_ctl();
      req = 0; flag_wr = 0; zero_in = 0; carry_in = 0; neg_in = 0;
      br_en = 0; br_cond = 2'b00; abs_en = 0; rel_en = 0;
      call_en = 0; ret_en = 0; target = '0; offset = '0;
   endtask

   task automatic compare_all();
      check("pc", 32'(prog_ctr), 32'(m_pc));
      check("running", 32'(running), 32'(m_st == M_RUN));
      check("done", 32'(done), 32'(m_st == M_DONE));
      check("stk_err", 32'(stk_err), 32'(m_err));
      check("cycles", 32'(cycles), 32'(m_cyc));
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
      compare_all();
   endtask

   task automatic do_reset();
      clear_ctl();
      reset = 1;
      tick();
      reset = 0;
   endtask

   task automatic start();
      clear_ctl();
      req = 1;
      tick();
      req = 0;
   endtask

   task automatic run_to(int pc);
      int n = 0;
      clear_ctl();
      while (m_pc != pc && n < 5000) begin
         tick();
         n++;
      end
      check("run_to", 32'(prog_ctr), 32'(pc));
   endtask

   initial begin
      clear_ctl();
      reset = 1;
      @(negedge clk);

      // Reset state
      step_name = "reset";
      do_reset();
      check("pc0", 32'(prog_ctr), 0);
      tick();
      check("idle_pc", 32'(prog_ctr), 0);

      // Straight-line run to the halt address
      step_name = "straight";
      start();
      check("run_start", 32'(running), 1);
      run_to(HALT);
      tick();
      check("halt_done", 32'(done), 1);
      check("halt_cycles", 32'(cycles), 129);
      tick();
      check("halt_pc", 32'(prog_ctr), HALT);
      check("halt_running", 32'(running), 0);

      // Conditional relative branches, including same-cycle flag write
      step_name = "cond_rel";
      start();
      run_to(5);
      flag_wr = 1; zero_in = 1;
      tick();
      clear_ctl();
      br_en = 1; br_cond = 2'b00; rel_en = 1; offset = 8'hFC;
      tick();
      check("z_taken", 32'(prog_ctr), 2);
      run_to(6);
      br_en = 1; br_cond = 2'b01; rel_en = 1; offset = 8'hFC;
      tick();
      check("nz_fall", 32'(prog_ctr), 7);
      clear_ctl();
      flag_wr = 1; zero_in = 0; br_en = 1; br_cond = 2'b00; rel_en = 1; offset = 8'hFC;
      tick();
      check("old_flag", 32'(prog_ctr), 3);
      clear_ctl();
      br_en = 1; br_cond = 2'b00; rel_en = 1; offset = 8'hFC;
      tick();
      check("new_flag", 32'(prog_ctr), 4);

      // Call / return and stack overflow
      step_name = "call_ret";
      run_to(10);
      call_en = 1; target = 12'd50;
      tick();
      check("call", 32'(prog_ctr), 50);
      run_to(52);
      ret_en = 1;
      tick();
      check("ret", 32'(prog_ctr), 11);
      for (int i = 1; i <= 5; i++) begin
         clear_ctl();
         call_en = 1; target = D'(i * 100);
         tick();
      end
      check("ovf_err", 32'(stk_err), 1);
      check("ovf_done", 32'(done), 1);
      check("ovf_pc", 32'(prog_ctr), 400);

      // Underflow, then call/return conflict
      step_name = "underflow";
      start();
      check("restart_err", 32'(stk_err), 0);
      check("restart_pc", 32'(prog_ctr), 0);
      clear_ctl();
      ret_en = 1;
      tick();
      check("udf_err", 32'(stk_err), 1);
      check("udf_done", 32'(done), 1);
      step_name = "conflict";
      start();
      run_to(3);
      call_en = 1; ret_en = 1; target = 12'd60;
      tick();
      check("cfl_err", 32'(stk_err), 1);
      check("cfl_pc", 32'(prog_ctr), 3);

      // Wrap-around and abs-over-rel precedence
      step_name = "wrap";
      start();
      run_to(2);
      abs_en = 1; target = 12'd4092;
      tick();
      clear_ctl();
      rel_en = 1; offset = 8'd8;
      tick();
      check("wrap_pc", 32'(prog_ctr), 4);
      clear_ctl();
      abs_en = 1; rel_en = 1; target = 12'd77; offset = 8'd5;
      tick();
      check("abs_wins", 32'(prog_ctr), 77);
      clear_ctl();
      abs_en = 1; target = 12'd4095;
      tick();
      clear_ctl();
      tick();
      check("inc_wrap", 32'(prog_ctr), 0);

      // Reset in the middle of a run
      step_name = "mid_reset";
      run_to(37);
      do_reset();
      check("mr_pc", 32'(prog_ctr), 0);
      check("mr_cycles", 32'(cycles), 0);
      check("mr_running", 32'(running), 0);

      // Random control traffic
      step_name = "random";
      for (int i = 0; i < 3000; i++) begin
         clear_ctl();
         reset    = ($urandom_range(299) == 0);
         req      = ($urandom_range(3) == 0);
         flag_wr  = ($urandom_range(2) == 0);
         zero_in  = 1'($urandom);
         carry_in = 1'($urandom);
         neg_in   = 1'($urandom);
         br_en    = 1'($urandom);
         br_cond  = 2'($urandom);
         abs_en   = ($urandom_range(5) == 0);
         rel_en   = ($urandom_range(5) == 0);
         call_en  = ($urandom_range(9) == 0);
         ret_en   = ($urandom_range(9) == 0);
         target   = D'($urandom_range(199));
         offset   = OW'($urandom);
         tick();
      end
      reset = 0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
